// File: rtl/fc_output_arbiter.sv
// Round-robin arbiter sharing one output FIFO write port among serialized FC layers.
// A grant is held for a whole packet so words from different requesters never interleave.
module fc_output_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned PACKET_LEN = 5,
    parameter int unsigned WORD_SIZE  = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  wen_i,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]   data_i,
    output logic [NUM_REQ-1:0]                  full_o,
    output logic                                wen_o,
    input  logic                                full_i,
    output logic [WORD_SIZE-1:0]                data_o,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(PACKET_LEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(PACKET_LEN - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] g_q, g_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] cand;
    logic            bad_write;

    // Search order last+1, last+2, ... so the requester just served ranks lowest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_q) + k) % NUM_REQ);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            g_q     <= '0;
            last_q  <= LastIdx;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Writes from non-granted requesters, or into a full FIFO, are dropped and flagged.
    assign bad_write = (|(wen_i & ~grant_o)) | (busy_o & wen_i[g_q] & full_i);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q | bad_write;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    g_d     = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (wen_o) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        full_o  = '1;
        wen_o   = 1'b0;
        data_o  = '0;
        grant_o = '0;
        busy_o  = 1'b0;
        err_o   = err_q;
        if (state_q == StGrant) begin
            full_o[g_q]  = full_i;
            wen_o        = wen_i[g_q] & ~full_i;
            data_o       = data_i[g_q];
            grant_o[g_q] = 1'b1;
            busy_o       = 1'b1;
        end
    end

endmodule
